// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master core: FSM state encoding and the
// default frame format (width, clock polarity, clock phase).
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_XFER  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_FIN   = 3'd4
  } spi_state_e;

  localparam int SPI_DATA_W_DEF = 8;
  localparam bit SPI_CPOL_DEF   = 1'b0;
  localparam bit SPI_CPHA_DEF   = 1'b0;

  // Edge counter width: one extra bit so 2*DATA_W fits without wrapping.
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// Request/response and serial-line bundle of the SPI master core. The core
// uses the master view; the environment (requester and slave) the slave view.
interface spi_master_core_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
);
  logic              START;
  logic [DATA_W-1:0] TX_DATA;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic              CS_N;
  logic [DATA_W-1:0] RX_DATA;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  START, TX_DATA, MISO,
    output SCLK, MOSI, CS_N, RX_DATA, BUSY, DONE
  );

  modport slave (
    output START, TX_DATA, MISO,
    input  SCLK, MOSI, CS_N, RX_DATA, BUSY, DONE
  );
endinterface

// File: rtl/spi_master_core.sv
// Single-frame SPI master: shifts DATA_W bits MSB first in the configured
// CPOL/CPHA mode, pacing every SCLK half-period on an external TICK_I strobe.
module spi_master_core
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter bit CPOL   = SPI_CPOL_DEF,
  parameter bit CPHA   = SPI_CPHA_DEF
) (
  input  logic               CLK_I,
  input  logic               RST,
  input  logic               TICK_I,
  spi_master_core_if.master  bus
);

  localparam int             EW        = edge_cnt_w(DATA_W);
  localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic              rx_bit_q, rx_bit_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;
    rx_bit_d  = rx_bit_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          shift_d = bus.TX_DATA;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LEAD;
          if (!CPHA) begin
            mosi_d = bus.TX_DATA[DATA_W-1];
          end else begin
            mosi_d = mosi_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LEAD: begin
        if (TICK_I) begin
          edge_d  = '0;
          state_d = ST_XFER;
        end else begin
          state_d = ST_LEAD;
        end
      end

      ST_XFER: begin
        if (TICK_I) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          // Mode 0 parks the sampled bit until the shift edge so the
          // outgoing LSB is not overwritten before it is sent.
          if (!edge_q[0]) begin
            if (CPHA) begin
              mosi_d = shift_q[DATA_W-1];
            end else begin
              rx_bit_d = bus.MISO;
            end
          end else begin
            shift_d = {shift_q[DATA_W-2:0], (CPHA ? bus.MISO : rx_bit_q)};
            if (!CPHA && (edge_q != LAST_EDGE)) begin
              mosi_d = shift_q[DATA_W-2];
            end else begin
              mosi_d = mosi_q;
            end
          end
          if (edge_q == LAST_EDGE) begin
            edge_d  = '0;
            state_d = ST_TRAIL;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end

      ST_TRAIL: begin
        if (TICK_I) begin
          cs_n_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_TRAIL;
        end
      end

      ST_FIN: begin
        rx_data_d = shift_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge CLK_I or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      rx_bit_q  <= 1'b0;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
      rx_bit_q  <= rx_bit_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.SCLK    = sclk_q;
  assign bus.MOSI    = mosi_q;
  assign bus.CS_N    = cs_n_q;
  assign bus.RX_DATA = rx_data_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: a mode-0 and a mode-3 instance run the same
// request stream; a slave model per instance plus a scoreboard check each frame.
module tb_spi_master_core;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          tick_at_edge;
  logic          start;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] slave_word [2];
  logic          loop_en [2];
  logic          cs_n_w [2];
  logic          sclk_w [2];
  logic          busy_w [2];
  logic          done_w [2];
  logic [DW-1:0] rx_w [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_period = 4;

  always #5 clk = ~clk;
  always @(posedge clk) tick_at_edge <= tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Strobe source: 1 = every cycle, 0 = random, N = every Nth cycle.
  initial begin : tick_gen
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_period == 1) begin
        tick = 1'b1;
      end else if (tick_period == 0) begin
        tick = ($urandom_range(0, 2) == 0);
      end else begin
        div  = (div + 1) % tick_period;
        tick = (div == 0);
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit MODE_CPOL = (g == 1);
    localparam bit MODE_CPHA = (g == 1);

    spi_master_core_if #(.DATA_W(DW)) bus ();

    logic          miso_r;
    logic [DW-1:0] cap_tx;
    int            cap_edges;
    int            cap_rises;

    assign bus.START   = start;
    assign bus.TX_DATA = tx_data;
    assign bus.MISO    = loop_en[g] ? bus.MOSI : miso_r;
    assign cs_n_w[g]   = bus.CS_N;
    assign sclk_w[g]   = bus.SCLK;
    assign busy_w[g]   = bus.BUSY;
    assign done_w[g]   = bus.DONE;
    assign rx_w[g]     = bus.RX_DATA;

    spi_master_core #(
      .DATA_W (DW),
      .CPOL   (MODE_CPOL),
      .CPHA   (MODE_CPHA)
    ) u_dut (
      .CLK_I  (clk),
      .RST    (rst),
      .TICK_I (tick),
      .bus    (bus.master)
    );

    // SPI slave: answers slave_word, records what it saw on MOSI.
    initial begin : slave
      logic [DW-1:0] sh;
      logic [DW-1:0] mrx;
      int            edges;
      int            rises;
      logic          prev_cs;
      logic          prev_sclk;
      logic          leading;
      miso_r = 1'b0; prev_cs = 1'b1; prev_sclk = MODE_CPOL;
      sh = '0; mrx = '0; edges = 0; rises = 0;
      cap_tx = '0; cap_edges = 0; cap_rises = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_cs = 1'b1; prev_sclk = MODE_CPOL; miso_r = 1'b0;
        end else begin
          if (prev_cs && !bus.CS_N) begin
            sh = slave_word[g]; mrx = '0; edges = 0; rises = 0;
            if (!MODE_CPHA) miso_r = sh[DW-1];
          end else if (!bus.CS_N && (bus.SCLK != prev_sclk)) begin
            edges++;
            if (bus.SCLK) rises++;
            leading = (bus.SCLK != MODE_CPOL);
            if (leading != MODE_CPHA) begin
              mrx = {mrx[DW-2:0], bus.MOSI};
            end else if (!MODE_CPHA) begin
              sh = sh << 1; miso_r = sh[DW-1];
            end else begin
              miso_r = sh[DW-1]; sh = sh << 1;
            end
          end
          if (!prev_cs && bus.CS_N) begin
            cap_tx = mrx; cap_edges = edges; cap_rises = rises;
          end
          prev_cs = bus.CS_N; prev_sclk = bus.SCLK;
        end
      end
    end

    // Scoreboard monitor: every DONE pops one expected exchange.
    initial begin : monitor
      exp_t e;
      logic have;
      logic m_prev_cs;
      logic exp_done;
      int   m_ticks;
      int   last_ticks;
      m_prev_cs = 1'b1; exp_done = 1'b0; m_ticks = 0; last_ticks = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          m_prev_cs = 1'b1; exp_done = 1'b0; m_ticks = 0;
        end else begin
          if (!m_prev_cs && tick_at_edge) m_ticks++;
          if (bus.DONE) begin
            check($sformatf("done_timing%0d", g), 32'(exp_done), 32'd1);
            have = 1'b0;
            if (g == 0) begin
              if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            end else begin
              if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            end
            check($sformatf("done_expected%0d", g), 32'(have), 32'd1);
            if (have) begin
              check($sformatf("rx_data%0d", g), 32'(bus.RX_DATA), 32'(e.rx));
              check($sformatf("mosi_bits%0d", g), 32'(cap_tx), 32'(e.tx));
              check($sformatf("sclk_edges%0d", g), 32'(cap_edges), 32'(2 * DW));
              check($sformatf("sclk_rises%0d", g), 32'(cap_rises), 32'(DW));
              check($sformatf("tick_latency%0d", g), 32'(last_ticks), 32'(2 * DW + 2));
            end
            check($sformatf("busy_at_done%0d", g), 32'(bus.BUSY), 32'd0);
            check($sformatf("sclk_idle%0d", g), 32'(bus.SCLK), 32'(MODE_CPOL));
            check($sformatf("cs_n_at_done%0d", g), 32'(bus.CS_N), 32'd1);
          end else if (exp_done) begin
            check($sformatf("done_missing%0d", g), 32'(bus.DONE), 32'd1);
          end
          exp_done = !m_prev_cs && bus.CS_N;
          if (exp_done) begin
            last_ticks = m_ticks; m_ticks = 0;
          end
          m_prev_cs = bus.CS_N;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1]) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[0] || busy_w[1]) check("idle_timeout", 32'(busy_w[0]), 32'd0);
  endtask

  task automatic wait_ticks(input int count);
    int n;
    int guard;
    n = 0; guard = 0;
    while ((n < count) && (guard < 2000)) begin
      @(negedge clk);
      guard++;
      if (tick_at_edge) n++;
    end
    if (n < count) check("tick_wait_timeout", 32'(n), 32'(count));
  endtask

  // Issue one frame; the exchange model is simply "slave receives tx,
  // master receives whatever the slave (or the loopback) offered".
  task automatic send_frame(input logic [DW-1:0] tx, input logic l0, input logic l1,
                            input logic [DW-1:0] sw0, input logic [DW-1:0] sw1,
                            input int inject);
    wait_idle();
    loop_en[0] = l0; loop_en[1] = l1;
    slave_word[0] = sw0; slave_word[1] = sw1;
    start = 1'b1; tx_data = tx;
    exp_q0.push_back({tx, (l0 ? tx : sw0)});
    exp_q1.push_back({tx, (l1 ? tx : sw1)});
    @(negedge clk);
    start = 1'b0; tx_data = DW'($urandom);
    if (inject > 0) begin
      wait_ticks(inject);
      start = 1'b1; tx_data = '1;
      @(negedge clk);
      start = 1'b0;
      if (inject < 2 * DW + 2) check("busy_after_restart", 32'(busy_w[0]), 32'd1);
    end
  endtask

  initial begin : stimulus
    int drain;
    rst = 1'b1; start = 1'b0; tx_data = '0;
    loop_en[0] = 1'b1; loop_en[1] = 1'b0;
    slave_word[0] = '0; slave_word[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_cs_n%0d", i), 32'(cs_n_w[i]), 32'd1);
      check($sformatf("reset_sclk%0d", i), 32'(sclk_w[i]), 32'(i));
      check($sformatf("reset_busy%0d", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("reset_rx%0d", i), 32'(rx_w[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Mode-0 loopback, mode-3 slave returning 0x3C.
    send_frame(8'hA5, 1'b1, 1'b0, 8'h00, 8'h3C, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 8'h00, 8'h3C, 0);
    // Restart attempts mid-frame and in the FIN cycle are ignored.
    send_frame(8'h96, 1'b1, 1'b0, 8'h00, 8'h69, 5);
    send_frame(8'h4B, 1'b0, 1'b1, 8'hE1, 8'h00, 2 * DW + 2);

    // Reset in the middle of a 0x5A frame.
    wait_idle();
    loop_en[0] = 1'b1; loop_en[1] = 1'b1;
    start = 1'b1; tx_data = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    wait_ticks(9);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_cs_n%0d", i), 32'(cs_n_w[i]), 32'd1);
      check($sformatf("abort_sclk%0d", i), 32'(sclk_w[i]), 32'(i));
      check($sformatf("abort_busy%0d", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("abort_done%0d", i), 32'(done_w[i]), 32'd0);
      check($sformatf("abort_rx%0d", i), 32'(rx_w[i]), 32'd0);
    end
    exp_q0.delete(); exp_q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h81, 1'b1, 1'b1, 8'h00, 8'h00, 0);

    // Strobe every cycle, back-to-back frames.
    wait_idle();
    tick_period = 1;
    send_frame(8'h01, 1'b1, 1'b1, 8'h00, 8'h00, 0);
    send_frame(8'h80, 1'b1, 1'b1, 8'h00, 8'h00, 0);

    // Randomized traffic at mixed strobe rates.
    for (int i = 0; i < 30; i++) begin
      wait_idle();
      case ($urandom_range(0, 4))
        0:       tick_period = 0;
        1:       tick_period = 1;
        2:       tick_period = 2;
        3:       tick_period = 3;
        default: tick_period = 5;
      endcase
      send_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom), DW'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * DW + 2)) : 0);
    end

    drain = 0;
    while (((exp_q0.size() + exp_q1.size()) != 0) && (drain < 5000)) begin
      @(negedge clk);
      drain++;
    end
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per SPI frame (legal 4..16).
REQ-002 SHALL have parameter CPOL, default 0, idle level of SCLK.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have port CLK_I  input  1  system clock; all logic on posedge CLK_I (single clock domain).
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port TICK_I  input  1  one-cycle strobe from the frequency divider; each strobe marks one SCLK half-period.
REQ-007 SHALL have port START  input  1  request a frame; sampled only in IDLE.
REQ-008 SHALL have port TX_DATA  input  DATA_W  frame to transmit, MSB first; captured on accepted START.
REQ-009 SHALL have port MISO  input  1  serial data from slave.
REQ-010 SHALL have port SCLK  output  1  SPI clock.
REQ-011 SHALL have port MOSI  output  1  serial data to slave.
REQ-012 SHALL have port CS_N  output  1  slave select, active-low.
REQ-013 SHALL have port RX_DATA  output  DATA_W  last received frame, held until the next DONE.
REQ-014 SHALL have port BUSY  output  1  high from accepted START until DONE.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse at frame end.

Function
REQ-016 SHALL implement FSM states IDLE, LEAD, XFER, TRAIL, FIN.
REQ-017 IDLE: START=1 -> capture TX_DATA into shift register, CS_N=0, BUSY=1, MOSI=TX_DATA[DATA_W-1] when CPHA=0, go LEAD next cycle; TICK_I ignored.
REQ-018 LEAD: first TICK_I -> XFER with edge counter = 0; SCLK unchanged.
REQ-019 XFER: each TICK_I toggles SCLK and increments edge counter (width ceil(log2(2*DATA_W))+1).
REQ-020 CPHA=0: even edge index samples MISO into shift LSB; odd edge index shifts and drives next MSB on MOSI.
REQ-021 CPHA=1: even edge index shifts out the next bit on MOSI (first bit on edge 0); odd edge index samples MISO.
REQ-022 Edge index 2*DATA_W-1 handled -> TRAIL; SCLK SHALL then equal CPOL.
REQ-023 TRAIL: next TICK_I -> FIN, CS_N=1.
REQ-024 FIN: one cycle; RX_DATA <= shift register; DONE=1; BUSY=0 same cycle; return to IDLE.
REQ-025 Frame latency: exactly 2*DATA_W+2 TICK_I strobes from START acceptance to CS_N rising; DONE one cycle later.
REQ-026 START while BUSY=1 SHALL be ignored (no queueing); TX_DATA changes during a frame SHALL have no effect.
REQ-027 START asserted in FIN cycle SHALL be ignored; START in IDLE cycle after FIN SHALL be accepted (back-to-back frames, CS_N high ≥1 cycle).
REQ-028 TICK_I held high continuously SHALL be treated as one strobe per cycle (fastest legal rate).
REQ-029 SCLK SHALL equal CPOL in IDLE, LEAD, TRAIL, FIN.
REQ-030 No TICK_I pulses -> FSM SHALL wait indefinitely in LEAD/XFER/TRAIL with outputs stable.

Reset
REQ-031 RST=1 SHALL immediately force: state IDLE, SCLK=CPOL, CS_N=1, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, counters 0.
REQ-032 RST mid-frame SHALL abort without DONE; RX_DATA SHALL read 0.
REQ-033 First START after RST deassertion SHALL be accepted normally.

Structure
REQ-034 A shared package spi_pkg SHALL hold the FSM state encoding and default DATA_W/CPOL/CPHA constants.
REQ-035 The module SHALL be flat; the frequency divider remains a separate instance supplying TICK_I, not a sub-module.

Verification
REQ-036 Mode 0, DATA_W=8, MOSI looped to MISO, TICK_I every 4th cycle, TX_DATA=0xA5 -> RX_DATA=0xA5, DONE after 18 ticks, 8 SCLK rising edges, SCLK idles 0.
REQ-037 CPOL=1 CPHA=1, slave model returns 0x3C, TX_DATA=0xC3 -> MOSI bits 1,1,0,0,0,0,1,1 on leading edges, RX_DATA=0x3C, SCLK idles 1.
REQ-038 START pulsed again at tick 5 of a frame with TX_DATA=0xFF -> ignored, original frame and RX_DATA unaffected, single DONE.
REQ-039 RST asserted at tick 9 of frame 0x5A -> same-cycle CS_N=1, SCLK=CPOL, BUSY=0, no DONE, RX_DATA=0; next frame 0x81 loops back correctly.
REQ-040 TICK_I tied high, two back-to-back frames 0x01 then 0x80 -> each 18 cycles of ticks, CS_N high exactly 1+ cycles between, two DONE pulses, RX_DATA 0x01 then 0x80.
